// File: rtl/common_pkg.sv
// Shared types for the systolic matrix-multiply datapath: lane payload and feeder FSM states.
package common_pkg;

    localparam int unsigned DATA_WIDTH = 16;

    // One lane element travelling into the PE array edge.
    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } matrix_data_t;

    // Zero bubble pushed into skew lines whenever no operand is accepted.
    localparam matrix_data_t MATRIX_BUBBLE = '{last: 1'b0, data: '0};

    typedef enum logic [1:0] {
        FEED_IDLE  = 2'd0,
        FEED_LOAD  = 2'd1,
        FEED_FLUSH = 2'd2,
        FEED_DONE  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/matrix_feeder_skew_line.sv
// skew_line: DEPTH-stage shift register of lane elements; lane i of the feeder uses DEPTH = i+1.
module skew_line
    import common_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  matrix_data_t in_i,
    output matrix_data_t out_o
);

    matrix_data_t stage_q [DEPTH];

    // Shift one stage per cycle; reset flushes the line to bubbles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= MATRIX_BUBBLE;
            end
        end else begin
            stage_q[0] <= in_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/matrix_feeder.sv
// matrix_feeder: accepts N-element operand vectors and emits them as a diagonal
// wavefront (lane i delayed i+1 cycles) into one edge of the PE array.
// Optional build macro FEEDER_BUBBLE_CNT_EN adds bubble_cnt_o (LOAD cycles without a beat).
module matrix_feeder
    import common_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned K_MAX = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [$clog2(K_MAX+1)-1:0]   k_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [N*DATA_WIDTH-1:0]      in_data_i,
    output matrix_data_t [N-1:0]         out_o,
    output logic                         busy_o,
    output logic                         done_o
`ifdef FEEDER_BUBBLE_CNT_EN
    ,
    output logic [15:0]                  bubble_cnt_o
`endif
);

    localparam int unsigned KW = $clog2(K_MAX+1);
    localparam int unsigned FW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_SAT      = KW'(K_MAX);
    localparam logic [FW-1:0] FLUSH_LAST = FW'((N > 1) ? (N - 2) : 0);

    feeder_state_t   state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            ready_d, busy_d, done_d;
    logic            beat_acc;
    logic            beat_last;

    assign beat_acc  = in_valid_i && in_ready_o;
    assign beat_last = (beat_cnt_q + KW'(1)) == k_q;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        ready_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            FEED_IDLE: begin
                if (start_i) begin
                    if (k_i == '0) begin
                        state_d = FEED_DONE;
                    end else begin
                        state_d    = FEED_LOAD;
                        k_d        = (k_i > K_SAT) ? K_SAT : k_i;
                        beat_cnt_d = '0;
                    end
                end
            end
            FEED_LOAD: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + KW'(1);
                    if (beat_last) begin
                        flush_cnt_d = '0;
                        state_d     = (N > 1) ? FEED_FLUSH : FEED_DONE;
                    end
                end
            end
            FEED_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = FEED_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            FEED_DONE: begin
                state_d = FEED_IDLE;
            end
            default: begin
                state_d = FEED_IDLE;
            end
        endcase

        ready_d = (state_d == FEED_LOAD);
        busy_d  = (state_d == FEED_LOAD) || (state_d == FEED_FLUSH);
        done_d  = (state_d == FEED_DONE);
    end

    // State, counters and handshake/status flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FEED_IDLE;
            k_q         <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            in_ready_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            in_ready_o  <= ready_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
        end
    end

    // One skew line per lane; lane i is i+1 stages deep.
    for (genvar i = 0; i < N; i++) begin : g_lane
        matrix_data_t lane_in;

        // Accepted element or a zero bubble enters the line.
        always_comb begin
            lane_in = MATRIX_BUBBLE;
            if (beat_acc) begin
                lane_in.last = beat_last;
                lane_in.data = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        skew_line #(
            .DEPTH (i + 1)
        ) u_skew_line (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .in_i   (lane_in),
            .out_o  (out_o[i])
        );
    end

`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q;

    // Saturating count of LOAD cycles with no accepted beat, cleared by a new start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bubble_cnt_q <= '0;
        end else if ((state_q == FEED_IDLE) && start_i) begin
            bubble_cnt_q <= '0;
        end else if ((state_q == FEED_LOAD) && !beat_acc && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_matrix_feeder.sv
// Directed bench for matrix_feeder (N=4, K_MAX=16): per-cycle vector table plus
// hand sequences for k=0, k above K_MAX and reset during LOAD.
module tb_matrix_feeder;
    import common_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned K_MAX = 16;
    localparam int unsigned KW    = $clog2(K_MAX+1);

    typedef matrix_data_t [N-1:0] lanes_t;

    typedef struct {
        logic                    start;
        logic [KW-1:0]           k;
        logic                    valid;
        logic [N*DATA_WIDTH-1:0] data;
        logic                    e_ready;
        logic                    e_busy;
        logic                    e_done;
        lanes_t                  e_out;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [KW-1:0]           k = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] in_data = '0;
    lanes_t                  lanes_out;
    logic                    busy;
    logic                    done;
`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0]             bubble_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    matrix_feeder #(
        .N     (N),
        .K_MAX (K_MAX)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .k_i        (k),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_o      (lanes_out),
        .busy_o     (busy),
        .done_o     (done)
`ifdef FEEDER_BUBBLE_CNT_EN
        ,
        .bubble_cnt_o (bubble_cnt)
`endif
    );

    // Negative value encodes an element carrying last=1.
    function automatic matrix_data_t md(input int v);
        matrix_data_t r;
        r.last = (v < 0);
        r.data = DATA_WIDTH'((v < 0) ? -v : v);
        return r;
    endfunction

    function automatic lanes_t lanes(input int a0, input int a1, input int a2, input int a3);
        lanes_t r;
        r[0] = md(a0);
        r[1] = md(a1);
        r[2] = md(a2);
        r[3] = md(a3);
        return r;
    endfunction

    function automatic logic [N*DATA_WIDTH-1:0] vecd(input int a, input int b, input int c, input int d);
        return {DATA_WIDTH'(d), DATA_WIDTH'(c), DATA_WIDTH'(b), DATA_WIDTH'(a)};
    endfunction

    task automatic add(input logic s, input int kk, input logic v, input logic [N*DATA_WIDTH-1:0] d,
                       input logic r, input logic b, input logic dn, input lanes_t o);
        vec_t x;
        x.start = s;
        x.k = KW'(kk);
        x.valid = v;
        x.data = d;
        x.e_ready = r;
        x.e_busy = b;
        x.e_done = dn;
        x.e_out = o;
        tbl.push_back(x);
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic s, input int kk, input logic v, input logic [N*DATA_WIDTH-1:0] d);
        start = s;
        k = KW'(kk);
        in_valid = v;
        in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic r, input logic b, input logic dn, input lanes_t o);
        n_vec++;
        if (in_ready !== r || busy !== b || done !== dn || lanes_out !== o) begin
            n_bad++;
            $display("FAIL %s: ready/busy/done=%b%b%b out=%h, expected %b%b%b out=%h",
                     name, in_ready, busy, done, lanes_out, r, b, dn, o);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // Basic k=3 matrix; start pulses in LOAD, FLUSH and DONE must be ignored.
        add(1, 3, 0, '0,                       1, 1, 0, lanes(0, 0, 0, 0));
        add(0, 0, 1, vecd(1, 2, 3, 4),         1, 1, 0, lanes(1, 0, 0, 0));
        add(1, 7, 1, vecd(5, 6, 7, 8),         1, 1, 0, lanes(5, 2, 0, 0));
        add(0, 0, 1, vecd(9, 10, 11, 12),      0, 1, 0, lanes(-9, 6, 3, 0));
        add(1, 2, 1, vecd(99, 99, 99, 99),     0, 1, 0, lanes(0, -10, 7, 4));
        add(0, 0, 0, '0,                       0, 1, 0, lanes(0, 0, -11, 8));
        add(0, 0, 0, '0,                       0, 0, 1, lanes(0, 0, 0, -12));
        add(1, 5, 0, '0,                       0, 0, 0, lanes(0, 0, 0, 0));
        // Back-to-back k=2 matrix with two bubble cycles between beats.
        add(1, 2, 0, '0,                       1, 1, 0, lanes(0, 0, 0, 0));
        add(0, 0, 1, vecd(21, 22, 23, 24),     1, 1, 0, lanes(21, 0, 0, 0));
        add(0, 0, 0, vecd(57005, 1, 2, 3),     1, 1, 0, lanes(0, 22, 0, 0));
        add(0, 0, 0, vecd(4, 5, 57005, 6),     1, 1, 0, lanes(0, 0, 23, 0));
        add(0, 0, 1, vecd(31, 32, 33, 34),     0, 1, 0, lanes(-31, 0, 0, 24));
        add(0, 0, 0, '0,                       0, 1, 0, lanes(0, -32, 0, 0));
        add(0, 0, 0, '0,                       0, 1, 0, lanes(0, 0, -33, 0));
        add(0, 0, 0, '0,                       0, 0, 1, lanes(0, 0, 0, -34));
        add(0, 0, 0, '0,                       0, 0, 0, lanes(0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", 1'b0, 1'b0, 1'b0, lanes(0, 0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].start, int'(tbl[i].k), tbl[i].valid, tbl[i].data);
            check($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_out);
        end
`ifdef FEEDER_BUBBLE_CNT_EN
        check_int("bubble_cnt", int'(bubble_cnt), 2);
`endif

        // k=0: straight to DONE, no lane data.
        step(1, 0, 0, '0);
        check("k0_done", 1'b0, 1'b0, 1'b1, lanes(0, 0, 0, 0));
        step(0, 0, 1, vecd(1, 2, 3, 4));
        check("k0_idle", 1'b0, 1'b0, 1'b0, lanes(0, 0, 0, 0));
        step(0, 0, 0, '0);
        check("k0_quiet", 1'b0, 1'b0, 1'b0, lanes(0, 0, 0, 0));

        // k above K_MAX saturates: exactly K_MAX beats accepted.
        begin
            int beats = 0;
            int dones = 0;
            int lasts = 0;
            int last_val = -1;
            step(1, K_MAX + 5, 0, '0);
            for (int c = 0; c < 40; c++) begin
                logic acc;
                acc = in_ready;
                step(0, 0, 1, vecd(beats + 1, 100, 200, 300));
                if (acc) beats++;
                if (done) dones++;
                if (lanes_out[0].last) begin
                    lasts++;
                    last_val = int'(lanes_out[0].data);
                end
            end
            check_int("ksat_beats", beats, K_MAX);
            check_int("ksat_done_pulses", dones, 1);
            check_int("ksat_lane0_lasts", lasts, 1);
            check_int("ksat_lane0_last_data", last_val, K_MAX);
            check("ksat_idle", 1'b0, 1'b0, 1'b0, lanes(0, 0, 0, 0));
        end

        // Reset asserted after two beats of a k=4 matrix.
        step(1, 4, 0, '0);
        step(0, 0, 1, vecd(1, 2, 3, 4));
        step(0, 0, 1, vecd(5, 6, 7, 8));
        check("pre_reset", 1'b1, 1'b1, 1'b0, lanes(5, 2, 0, 0));
        rst_n = 1'b0;
        #1;
        check("in_reset", 1'b0, 1'b0, 1'b0, lanes(0, 0, 0, 0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step(0, 0, 1, vecd(9, 9, 9, 9));
        check("post_reset_idle", 1'b0, 1'b0, 1'b0, lanes(0, 0, 0, 0));
        step(0, 0, 1, vecd(9, 9, 9, 9));
        check("post_reset_no_accept", 1'b0, 1'b0, 1'b0, lanes(0, 0, 0, 0));

        // Normal k=1 matrix after reset.
        step(1, 1, 0, '0);
        check("k1_load", 1'b1, 1'b1, 1'b0, lanes(0, 0, 0, 0));
        step(0, 0, 1, vecd(7, 8, 9, 10));
        check("k1_lane0", 1'b0, 1'b1, 1'b0, lanes(-7, 0, 0, 0));
        step(0, 0, 0, '0);
        check("k1_lane1", 1'b0, 1'b1, 1'b0, lanes(0, -8, 0, 0));
        step(0, 0, 0, '0);
        check("k1_lane2", 1'b0, 1'b1, 1'b0, lanes(0, 0, -9, 0));
        step(0, 0, 0, '0);
        check("k1_lane3_done", 1'b0, 1'b0, 1'b1, lanes(0, 0, 0, -10));
        step(0, 0, 0, '0);
        check("k1_idle", 1'b0, 1'b0, 1'b0, lanes(0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
